// File: rtl/avg_line_raster.sv
// -----------------------------------------------------------------------------
// avg_line_raster
//
// Drain side of the line queue. Pops one line (start, end, colour) at a time and
// rasterises it with integer Bresenham into a stream of pixel writes, one pixel
// per cycle while the sink is ready. Line coordinates are signed and
// centre-origin. They are mapped to unsigned screen coordinates:
//   screen_x = x + SCREEN_W/2
//   screen_y = SCREEN_H/2 - y
//
// Parameters
//   CW        line coordinate width (signed two's complement)
//   SCREEN_W  screen width in pixels
//   SCREEN_H  screen height in pixels
//   PW        pixel coordinate output width (PW <= CW+1)
//
// Ports
//   clk, rst_b                 clock, asynchronous active-low reset
//   qStartX/Y, qEndX/Y, qColor head-of-queue line, valid while !qEmpty
//   qEmpty                     queue empty flag
//   qRead                      one-cycle pop strobe to the queue
//   pixX, pixY, pixColor       current pixel (screen coordinates, colour)
//   pixValid / pixReady        pixel handshake; data held stable while stalled
//   busy                       high whenever a line is being set up or drawn
//
// Optional feature (compile-time macro AVG_RASTER_CLIP_EN)
//   When defined, pixels outside the visible screen are still stepped through
//   (one cycle each, no handshake) but pixValid stays low for them.
//   When undefined, every pixel is emitted and its coordinates wrap to PW bits.
// -----------------------------------------------------------------------------
module avg_line_raster #(
    parameter int CW       = 11,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int PW       = 10
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic [CW-1:0] qStartX,
    input  logic [CW-1:0] qStartY,
    input  logic [CW-1:0] qEndX,
    input  logic [CW-1:0] qEndY,
    input  logic [2:0]    qColor,
    input  logic          qEmpty,
    output logic          qRead,
    output logic [PW-1:0] pixX,
    output logic [PW-1:0] pixY,
    output logic [2:0]    pixColor,
    output logic          pixValid,
    input  logic          pixReady,
    output logic          busy
);

    // Screen geometry in the signed CW+1 bit domain used for the mapping.
    localparam logic signed [CW:0] HALF_W = (CW+1)'(SCREEN_W / 2);
    localparam logic signed [CW:0] HALF_H = (CW+1)'(SCREEN_H / 2);
    localparam logic signed [CW:0] SCR_W  = (CW+1)'(SCREEN_W);
    localparam logic signed [CW:0] SCR_H  = (CW+1)'(SCREEN_H);
    localparam logic signed [CW-1:0] ONE  = CW'(1);

`ifdef AVG_RASTER_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched line
    logic signed [CW-1:0] x0_q, y0_q, x1_q, y1_q;
    logic [2:0]           color_q;

    // Bresenham state. dx >= 0, dy <= 0; both fit in CW+1 bits because the
    // largest coordinate difference is 2^CW - 1. err stays within about
    // 1.5x those magnitudes, so CW+2 bits cannot overflow.
    logic signed [CW:0]   dx_q, dy_q;
    logic                 sx_neg_q, sy_neg_q;
    logic signed [CW+1:0] err_q;
    logic signed [CW-1:0] cur_x_q, cur_y_q;

    // Registered pixel outputs plus on-screen flag for the current pixel
    logic [PW-1:0]        pix_x_q, pix_y_q;
    logic                 pix_vis_q;

    // Keeps qRead quiet during reset and for the first edge after release.
    logic                 armed_q;

    // -------------------------------------------------------------------------
    // Coordinate mapping
    // -------------------------------------------------------------------------
    function automatic logic signed [CW:0] map_x(input logic signed [CW-1:0] x);
        return $signed({x[CW-1], x}) + HALF_W;
    endfunction

    function automatic logic signed [CW:0] map_y(input logic signed [CW-1:0] y);
        return HALF_H - $signed({y[CW-1], y});
    endfunction

    function automatic logic on_screen(input logic signed [CW:0] mx,
                                       input logic signed [CW:0] my);
        return (mx >= 0) && (mx < SCR_W) && (my >= 0) && (my < SCR_H);
    endfunction

    // -------------------------------------------------------------------------
    // Setup arithmetic (from the latched line)
    // -------------------------------------------------------------------------
    logic signed [CW:0]   diff_x, diff_y, abs_dx, neg_dy;
    logic signed [CW+1:0] err_init;
    logic signed [CW:0]   start_mx, start_my;

    assign diff_x   = $signed({x1_q[CW-1], x1_q}) - $signed({x0_q[CW-1], x0_q});
    assign diff_y   = $signed({y1_q[CW-1], y1_q}) - $signed({y0_q[CW-1], y0_q});
    assign abs_dx   = diff_x[CW] ? -diff_x : diff_x;
    assign neg_dy   = diff_y[CW] ? diff_y : -diff_y;
    assign err_init = $signed({abs_dx[CW], abs_dx}) + $signed({neg_dy[CW], neg_dy});
    assign start_mx = map_x(x0_q);
    assign start_my = map_y(y0_q);

    // -------------------------------------------------------------------------
    // Step arithmetic (one Bresenham iteration)
    // -------------------------------------------------------------------------
    logic signed [CW+2:0] e2, dx_w, dy_w;
    logic                 step_x, step_y, at_end;
    logic signed [CW+1:0] err_next;
    logic signed [CW-1:0] nx, ny;
    logic signed [CW:0]   next_mx, next_my;

    assign e2     = $signed({err_q, 1'b0});
    assign dx_w   = $signed({{2{dx_q[CW]}}, dx_q});
    assign dy_w   = $signed({{2{dy_q[CW]}}, dy_q});
    assign step_x = (e2 >= dy_w);
    assign step_y = (e2 <= dx_w);

    // Both corrections apply together, giving a diagonal step.
    assign err_next = err_q
                    + (step_x ? $signed({dy_q[CW], dy_q}) : '0)
                    + (step_y ? $signed({dx_q[CW], dx_q}) : '0);

    assign nx = step_x ? (sx_neg_q ? cur_x_q - ONE : cur_x_q + ONE) : cur_x_q;
    assign ny = step_y ? (sy_neg_q ? cur_y_q - ONE : cur_y_q + ONE) : cur_y_q;

    assign next_mx = map_x(nx);
    assign next_my = map_y(ny);

    assign at_end  = (cur_x_q == x1_q) && (cur_y_q == y1_q);

    // -------------------------------------------------------------------------
    // Handshake / control
    // -------------------------------------------------------------------------
    logic pop, advance;

    assign pop     = (state_q == IDLE) && armed_q && !qEmpty;
    // A clipped pixel needs no handshake; it simply consumes its cycle.
    assign advance = (state_q == DRAW) && (!pix_vis_q || pixReady);

    assign qRead    = pop;
    assign busy     = (state_q != IDLE);
    assign pixValid = (state_q == DRAW) && pix_vis_q;
    assign pixX     = pix_x_q;
    assign pixY     = pix_y_q;
    assign pixColor = color_q;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop) state_d = SETUP;
            SETUP:   state_d = DRAW;
            DRAW:    if (advance && at_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            armed_q   <= 1'b0;
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            color_q   <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            sx_neg_q  <= 1'b0;
            sy_neg_q  <= 1'b0;
            err_q     <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            pix_vis_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        x0_q    <= $signed(qStartX);
                        y0_q    <= $signed(qStartY);
                        x1_q    <= $signed(qEndX);
                        y1_q    <= $signed(qEndY);
                        color_q <= qColor;
                    end
                end
                SETUP: begin
                    dx_q      <= abs_dx;
                    dy_q      <= neg_dy;
                    sx_neg_q  <= diff_x[CW];
                    sy_neg_q  <= diff_y[CW];
                    err_q     <= err_init;
                    cur_x_q   <= x0_q;
                    cur_y_q   <= y0_q;
                    pix_x_q   <= start_mx[PW-1:0];
                    pix_y_q   <= start_my[PW-1:0];
                    pix_vis_q <= !CLIP || on_screen(start_mx, start_my);
                end
                DRAW: begin
                    if (advance && !at_end) begin
                        err_q     <= err_next;
                        cur_x_q   <= nx;
                        cur_y_q   <= ny;
                        pix_x_q   <= next_mx[PW-1:0];
                        pix_y_q   <= next_my[PW-1:0];
                        pix_vis_q <= !CLIP || on_screen(next_mx, next_my);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_avg_line_raster.sv
// -----------------------------------------------------------------------------
// tb_avg_line_raster
//
// Scoreboard bench for avg_line_raster. The stimulus side feeds a model queue
// and pushes hand-computed pixels, per-line pixel counts and first-pixel
// latencies into expectation queues. An independent monitor on the falling
// edge pops and compares on every accepted pixel and on every pop strobe.
// Build with +define+AVG_RASTER_CLIP_EN to exercise the clipping variant.
// -----------------------------------------------------------------------------
module tb_avg_line_raster;

    localparam int CW = 11;
    localparam int PW = 10;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic [CW-1:0] qStartX, qStartY, qEndX, qEndY;
    logic [2:0]    qColor;
    logic          qEmpty;
    logic          qRead;
    logic [PW-1:0] pixX, pixY;
    logic [2:0]    pixColor;
    logic          pixValid;
    logic          pixReady = 1'b1;
    logic          busy;

    avg_line_raster #(.CW(CW), .SCREEN_W(640), .SCREEN_H(480), .PW(PW)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .qStartX  (qStartX),
        .qStartY  (qStartY),
        .qEndX    (qEndX),
        .qEndY    (qEndY),
        .qColor   (qColor),
        .qEmpty   (qEmpty),
        .qRead    (qRead),
        .pixX     (pixX),
        .pixY     (pixY),
        .pixColor (pixColor),
        .pixValid (pixValid),
        .pixReady (pixReady),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] x0, y0, x1, y1;
        logic [2:0]    c;
    } line_t;

    typedef struct packed {
        logic [PW-1:0] x, y;
        logic [2:0]    c;
    } px_t;

    line_t line_q[$];
    px_t   exp_q[$];
    int    cnt_q[$];
    int    lat_q[$];

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    logic  pop_pending = 1'b0;

    // Monitor bookkeeping
    logic  in_line = 1'b0, wait_first = 1'b0, prev_qread = 1'b0, prev_hold = 1'b0;
    int    cur_cnt = 0, qread_cyc = 0;
    px_t   prev_px;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic update_head();
        if (line_q.size() > 0) begin
            qStartX = line_q[0].x0;
            qStartY = line_q[0].y0;
            qEndX   = line_q[0].x1;
            qEndY   = line_q[0].y1;
            qColor  = line_q[0].c;
            qEmpty  = 1'b0;
        end else begin
            qStartX = '0;
            qStartY = '0;
            qEndX   = '0;
            qEndY   = '0;
            qColor  = '0;
            qEmpty  = 1'b1;
        end
    endtask

    task automatic exp_px(input int sx, input int sy, input int c);
        px_t p;
        p.x = sx[PW-1:0];
        p.y = sy[PW-1:0];
        p.c = c[2:0];
        exp_q.push_back(p);
    endtask

    task automatic add_line(input int x0, input int y0, input int x1, input int y1,
                            input int c, input int cnt, input int lat);
        line_t l;
        l.x0 = x0[CW-1:0];
        l.y0 = y0[CW-1:0];
        l.x1 = x1[CW-1:0];
        l.y1 = y1[CW-1:0];
        l.c  = c[2:0];
        cnt_q.push_back(cnt);
        lat_q.push_back(lat);
        line_q.push_back(l);
        update_head();
    endtask

    // Wait until the queue is drained, every expected pixel seen and the DUT
    // idle; then close out the pixel count of the last line.
    task automatic wait_idle(input int budget);
        int n = 0;
        forever begin
            @(negedge clk);
            if (line_q.size() == 0 && exp_q.size() == 0 && !busy) break;
            n++;
            if (n >= budget) begin
                n_checks++;
                n_fail++;
                $display("FAIL wait_idle: timeout after %0d cycles, %0d pixels outstanding",
                         budget, exp_q.size());
                break;
            end
        end
        if (in_line && cnt_q.size() > 0) check("line_pixels", cur_cnt, cnt_q.pop_front());
        in_line = 1'b0;
        exp_q.delete();
        cnt_q.delete();
        lat_q.delete();
        @(posedge clk);
        #1;
    endtask

    // Model queue: pop after the edge that consumed the strobe.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (pop_pending) begin
                #1;
                if (line_q.size() > 0) void'(line_q.pop_front());
                update_head();
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        pop_pending = qRead;
        if (rst_b) begin
            if (qRead) begin
                check("qread_pulse", {31'd0, prev_qread}, 32'd0);
                check("qread_while_busy", {31'd0, busy}, 32'd0);
                if (in_line && cnt_q.size() > 0) check("line_pixels", cur_cnt, cnt_q.pop_front());
                in_line    = 1'b1;
                cur_cnt    = 0;
                wait_first = 1'b1;
                qread_cyc  = cyc;
            end
            if (pixValid && wait_first) begin
                wait_first = 1'b0;
                if (lat_q.size() > 0) check("first_pixel_latency", cyc - qread_cyc, lat_q.pop_front());
            end
            if (prev_hold) begin
                check("hold_valid", {31'd0, pixValid}, 32'd1);
                check("hold_data", {9'd0, pixX, pixY, pixColor}, {9'd0, prev_px});
            end
            if (pixValid && pixReady) begin
                cur_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pixel: unexpected (%0d,%0d) c=%0d, none expected", pixX, pixY, pixColor);
                end else begin
                    check("pixel", {9'd0, pixX, pixY, pixColor}, {9'd0, exp_q.pop_front()});
                end
            end
            prev_qread = qRead;
            prev_hold  = pixValid && !pixReady;
            prev_px    = {pixX, pixY, pixColor};
        end else begin
            prev_qread = 1'b0;
            prev_hold  = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        update_head();

        // Reset state
        #1;
        check("rst_qread", {31'd0, qRead}, 32'd0);
        check("rst_valid", {31'd0, pixValid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pix", {9'd0, pixX, pixY, pixColor}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Horizontal line plus the (0,0)->(2,-5) steep line queued back to back
        for (int i = 0; i < 4; i++) exp_px(320 + i, 240, 5);
        exp_px(320, 240, 3); exp_px(320, 241, 3); exp_px(321, 242, 3);
        exp_px(321, 243, 3); exp_px(322, 244, 3); exp_px(322, 245, 3);
        add_line(0, 0, 3, 0, 5, 4, 2);
        add_line(0, 0, 2, -5, 3, 6, 2);
        wait_idle(200);

        // Zero-length line
        exp_px(327, 233, 6);
        add_line(7, 7, 7, 7, 6, 1, 2);
        wait_idle(100);

        // Backpressure mid-line
        for (int i = 0; i < 4; i++) exp_px(320, 240 - i, 2);
        add_line(0, 0, 0, 3, 2, 4, 2);
        repeat (4) @(posedge clk);
        #1 pixReady = 1'b0;
        repeat (3) @(posedge clk);
        #1 pixReady = 1'b1;
        wait_idle(100);

        // Line crossing the left screen edge
`ifdef AVG_RASTER_CLIP_EN
        for (int i = 10; i <= 20; i++) exp_px(i - 10, 240, 4);
        add_line(-330, 0, -310, 0, 4, 11, 12);
`else
        for (int i = 0; i <= 20; i++) exp_px(i - 10, 240, 4);
        add_line(-330, 0, -310, 0, 4, 21, 2);
`endif
        wait_idle(200);

        // Reset in the middle of a long line
        for (int i = 0; i <= 40; i++) exp_px(320 + i, 240, 1);
        add_line(0, 0, 40, 0, 1, 41, 2);
        repeat (8) @(posedge clk);
        #1 rst_b = 1'b0;
        line_q.delete();
        update_head();
        exp_q.delete();
        cnt_q.delete();
        lat_q.delete();
        in_line    = 1'b0;
        wait_first = 1'b0;
        #1;
        check("midrst_valid", {31'd0, pixValid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("postrst_no_qread", {31'd0, qRead}, 32'd0);
            check("postrst_no_valid", {31'd0, pixValid}, 32'd0);
        end
        @(posedge clk);
        #1;
        exp_px(327, 233, 7);
        add_line(7, 7, 7, 7, 7, 1, 2);
        wait_idle(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
